// File: rtl/cpu_mu0_param.sv
// MU0-style accumulator CPU with a parameterised address/data width and a
// waitrequest-stalled memory bus (single outstanding read or write).
module cpu_mu0_param #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              running,
    output logic              error,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    // The opcode field is exactly four bits wide.
    if (DATA_W != ADDR_W + 4) begin : g_width_check
        $error("cpu_mu0_param: DATA_W must equal ADDR_W+4");
    end

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALTED
    } state_t;

    typedef enum logic [3:0] {
        OP_LDA = 4'd0,
        OP_STO = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_JMP = 4'd4,
        OP_JGE = 4'd5,
        OP_JNE = 4'd6,
        OP_STP = 4'd7,
        OP_OUT = 4'd8,
        OP_LDI = 4'd9
    } opcode_t;

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] out_q, out_d;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [ADDR_W-1:0] pc_inc;

    assign opcode  = instr_q[DATA_W-1:ADDR_W];
    assign operand = instr_q[ADDR_W-1:0];
    assign pc_inc  = pc_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= PC_INIT;
            acc_q   <= '0;
            instr_q <= '0;
            error_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            instr_q <= instr_d;
            error_q <= error_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        instr_d   = instr_q;
        error_d   = error_q;
        out_d     = out_q;
        address   = pc_q;
        read      = 1'b0;
        write     = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: state_d = FETCH;

            FETCH: begin
                read = 1'b1;
                if (!waitrequest) begin
                    instr_d = readdata;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        address = operand;
                        read    = 1'b1;
                        if (!waitrequest) begin
                            if (opcode == OP_LDA)      acc_d = readdata;
                            else if (opcode == OP_ADD) acc_d = acc_q + readdata;
                            else                       acc_d = acc_q - readdata;
                            pc_d    = pc_inc;
                            state_d = FETCH;
                        end
                    end
                    OP_STO: begin
                        address = operand;
                        write   = 1'b1;
                        if (!waitrequest) begin
                            pc_d    = pc_inc;
                            state_d = FETCH;
                        end
                    end
                    OP_JMP: begin
                        pc_d    = operand;
                        state_d = FETCH;
                    end
                    OP_JGE: begin
                        pc_d    = acc_q[DATA_W-1] ? pc_inc : operand;
                        state_d = FETCH;
                    end
                    OP_JNE: begin
                        pc_d    = (acc_q != '0) ? operand : pc_inc;
                        state_d = FETCH;
                    end
                    OP_STP: state_d = HALTED;
                    OP_OUT: begin
                        out_valid = 1'b1;
                        out_d     = acc_q;
                        pc_d      = pc_inc;
                        state_d   = FETCH;
                    end
                    OP_LDI: begin
                        acc_d   = DATA_W'(operand);
                        pc_d    = pc_inc;
                        state_d = FETCH;
                    end
                    default: begin
                        error_d = 1'b1;
                        state_d = HALTED;
                    end
                endcase
            end

            HALTED: state_d = HALTED;

            default: state_d = IDLE;
        endcase
    end

    assign running   = (state_q == FETCH) || (state_q == EXEC);
    assign error     = error_q;
    assign writedata = acc_q;
    // The OUT value is visible during its strobe and held afterwards.
    assign out_data  = out_valid ? acc_q : out_q;

endmodule
